// File: rtl/traffic_pkg.sv
// Shared types and default timings for the four-road intersection phase scheduler.
package traffic_pkg;

   localparam int unsigned NUM_ROADS          = 4;
   localparam int unsigned DEF_GREEN_NORM     = 8;
   localparam int unsigned DEF_GREEN_JAM      = 12;
   localparam int unsigned DEF_YELLOW_CYC     = 3;
   localparam int unsigned DEF_ALLRED_CYC     = 2;
   localparam int unsigned DEF_MIN_GREEN      = 4;
   localparam int unsigned DEF_MAX_JAM_STREAK = 2;

   typedef logic [1:0] road_t;

   typedef enum logic [1:0] {
      PH_ALL_RED = 2'd0,
      PH_GREEN   = 2'd1,
      PH_YELLOW  = 2'd2
   } phase_e;

   function automatic logic [NUM_ROADS-1:0] road_onehot(input road_t road);
      road_onehot       = '0;
      road_onehot[road] = 1'b1;
   endfunction

endpackage

// File: rtl/rr_jam_picker.sv
// Combinational round-robin picker: first requesting road at or after i_ptr, wrapping mod 4.
module rr_jam_picker
   import traffic_pkg::*;
(
   input  logic [NUM_ROADS-1:0] i_req,
   input  road_t                i_ptr,
   output logic                 o_valid,
   output road_t                o_grant_idx
);

   always_comb begin
      o_valid     = |i_req;
      o_grant_idx = i_ptr;
      // Scan farthest-first so the nearest requester wins by being written last.
      for (int k = NUM_ROADS - 1; k >= 0; k--) begin
         if (i_req[i_ptr + road_t'(k)]) o_grant_idx = i_ptr + road_t'(k);
      end
   end

endmodule

// File: rtl/traffic_phase_sched.sv
// Intersection phase scheduler: GREEN -> YELLOW -> ALL_RED per road, round-robin service
// with jam priority, bounded jam streaks and preemption of normal greens.
module traffic_phase_sched
   import traffic_pkg::*;
#(
   parameter int unsigned GREEN_NORM     = DEF_GREEN_NORM,
   parameter int unsigned GREEN_JAM      = DEF_GREEN_JAM,
   parameter int unsigned YELLOW_CYC     = DEF_YELLOW_CYC,
   parameter int unsigned ALLRED_CYC     = DEF_ALLRED_CYC,
   parameter int unsigned MIN_GREEN      = DEF_MIN_GREEN,
   parameter int unsigned MAX_JAM_STREAK = DEF_MAX_JAM_STREAK
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_tick,
   input  logic [NUM_ROADS-1:0] i_jam_sensor,
   output logic [NUM_ROADS-1:0] o_allow,
   output logic [NUM_ROADS-1:0] o_yellow,
   output logic [1:0]           o_phase,
   output road_t                o_current_road,
   output logic                 o_jam_active,
   output logic                 o_phase_start
);

   localparam int unsigned MAX_GREEN = (GREEN_JAM > GREEN_NORM) ? GREEN_JAM : GREEN_NORM;
   localparam int unsigned MAX_AMBER = (YELLOW_CYC > ALLRED_CYC) ? YELLOW_CYC : ALLRED_CYC;
   localparam int unsigned MAX_DUR   = (MAX_GREEN > MAX_AMBER) ? MAX_GREEN : MAX_AMBER;
   localparam int unsigned TW        = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
   localparam int unsigned SW        = $clog2(MAX_JAM_STREAK + 1);

   phase_e                 r_phase,        w_phase_d;
   logic   [TW-1:0]        r_timer,        w_timer_d;
   road_t                  r_road,         w_road_d;
   road_t                  r_last_road,    w_last_road_d;
   road_t                  r_norm_next,    w_norm_next_d;
   logic                   r_jam_active,   w_jam_active_d;
   logic   [SW-1:0]        r_jam_streak,   w_jam_streak_d;
   logic                   r_phase_start,  w_phase_start_d;

   logic                   w_pick_valid;
   road_t                  w_pick_idx;
   road_t                  w_ptr;
   logic   [NUM_ROADS-1:0] w_road_oh;
   logic                   w_streak_ok;
   logic                   w_take_jam;
   road_t                  w_sel_road;
   logic                   w_preempt;

   assign w_ptr       = r_last_road + road_t'(1);
   assign w_road_oh   = road_onehot(r_road);
   assign w_streak_ok = r_jam_streak < SW'(MAX_JAM_STREAK);
   assign w_take_jam  = w_pick_valid && w_streak_ok;
   assign w_sel_road  = w_take_jam ? w_pick_idx : r_norm_next;
   // Timer <= GREEN_NORM-MIN_GREEN means this tick completes at least MIN_GREEN of service.
   assign w_preempt   = !r_jam_active && (|(i_jam_sensor & ~w_road_oh)) && w_streak_ok &&
                        (r_timer <= TW'(GREEN_NORM - MIN_GREEN));

   rr_jam_picker u_picker (
      .i_req       (i_jam_sensor),
      .i_ptr       (w_ptr),
      .o_valid     (w_pick_valid),
      .o_grant_idx (w_pick_idx)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_phase       <= PH_ALL_RED;
         r_timer       <= TW'(ALLRED_CYC - 1);
         r_road        <= '0;
         r_last_road   <= road_t'(NUM_ROADS - 1);
         r_norm_next   <= '0;
         r_jam_active  <= 1'b0;
         r_jam_streak  <= '0;
         r_phase_start <= 1'b0;
      end else begin
         r_phase       <= w_phase_d;
         r_timer       <= w_timer_d;
         r_road        <= w_road_d;
         r_last_road   <= w_last_road_d;
         r_norm_next   <= w_norm_next_d;
         r_jam_active  <= w_jam_active_d;
         r_jam_streak  <= w_jam_streak_d;
         r_phase_start <= w_phase_start_d;
      end
   end

   always_comb begin
      w_phase_d       = r_phase;
      w_timer_d       = r_timer;
      w_road_d        = r_road;
      w_last_road_d   = r_last_road;
      w_norm_next_d   = r_norm_next;
      w_jam_active_d  = r_jam_active;
      w_jam_streak_d  = r_jam_streak;
      w_phase_start_d = r_phase_start;
      if (i_tick) begin
         w_phase_start_d = 1'b0;
         unique case (r_phase)
            PH_ALL_RED: begin
               if (r_timer == '0) begin
                  w_phase_d       = PH_GREEN;
                  w_phase_start_d = 1'b1;
                  w_road_d        = w_sel_road;
                  w_last_road_d   = w_sel_road;
                  if (w_take_jam) begin
                     w_timer_d      = TW'(GREEN_JAM - 1);
                     w_jam_active_d = 1'b1;
                     w_jam_streak_d = r_jam_streak + SW'(1);
                  end else begin
                     w_timer_d      = TW'(GREEN_NORM - 1);
                     w_jam_active_d = 1'b0;
                     w_jam_streak_d = '0;
                     w_norm_next_d  = r_norm_next + road_t'(1);
                  end
               end else begin
                  w_timer_d = r_timer - TW'(1);
               end
            end
            PH_GREEN: begin
               if (r_timer == '0 || w_preempt) begin
                  w_phase_d = PH_YELLOW;
                  w_timer_d = TW'(YELLOW_CYC - 1);
               end else begin
                  w_timer_d = r_timer - TW'(1);
               end
            end
            PH_YELLOW: begin
               if (r_timer == '0) begin
                  w_phase_d = PH_ALL_RED;
                  w_timer_d = TW'(ALLRED_CYC - 1);
               end else begin
                  w_timer_d = r_timer - TW'(1);
               end
            end
            default: begin
               w_phase_d = PH_ALL_RED;
               w_timer_d = TW'(ALLRED_CYC - 1);
            end
         endcase
      end
   end

   always_comb begin
      o_allow  = '0;
      o_yellow = '0;
      unique case (r_phase)
         PH_GREEN:  o_allow  = w_road_oh;
         PH_YELLOW: o_yellow = w_road_oh;
         default:   ;
      endcase
   end

   assign o_phase        = r_phase;
   assign o_current_road = r_road;
   assign o_jam_active   = r_jam_active;
   assign o_phase_start  = r_phase_start;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Scoreboard bench: a tick-level reference model queues expected outputs per edge; a negedge
// monitor pops and compares, and also logs DUT greens for the scripted jam scenarios.
module tb_traffic_phase_sched;
   import traffic_pkg::*;

   localparam int GN = 8, GJ = 12, YC = 3, AR = 2, MG = 4, MJS = 2;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       tick = 1'b0;
   logic [3:0] jam  = 4'b0000;
   logic [3:0] allow, yellow;
   logic [1:0] phase;
   road_t      cur_road;
   logic       jam_active, phase_start;

   always #5 clk = ~clk;

   traffic_phase_sched #(
      .GREEN_NORM     (GN),
      .GREEN_JAM      (GJ),
      .YELLOW_CYC     (YC),
      .ALLRED_CYC     (AR),
      .MIN_GREEN      (MG),
      .MAX_JAM_STREAK (MJS)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_tick         (tick),
      .i_jam_sensor   (jam),
      .o_allow        (allow),
      .o_yellow       (yellow),
      .o_phase        (phase),
      .o_current_road (cur_road),
      .o_jam_active   (jam_active),
      .o_phase_start  (phase_start)
   );

   typedef struct {
      logic [3:0] allow;
      logic [3:0] yellow;
      int ph;
      int road;
      int jam;
      int ps;
   } exp_t;

   typedef struct {
      int road;
      int jam;
      int len;
   } grn_t;

   exp_t exp_q[$];
   grn_t green_log[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: phase, ticks served in it, and the scheduling memory.
   int m_ph = 0, m_served = 0, m_road = 0, m_jam = 0, m_norm = 0, m_last = 3;
   int m_streak = 0, m_len = GN, m_ps = 0;

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   task automatic model_step(input bit r, input bit t, input logic [3:0] j);
      exp_t e;
      bit   found;
      if (r) begin
         m_ph = 0; m_served = 0; m_road = 0; m_jam = 0; m_norm = 0; m_last = 3;
         m_streak = 0; m_len = GN; m_ps = 0;
      end else if (t) begin
         m_ps = 0;
         m_served++;
         case (m_ph)
            0: if (m_served == AR) begin
                  found = 1'b0;
                  if (j != 4'b0000 && m_streak < MJS) begin
                     for (int k = 1; k <= 4; k++) begin
                        if (!found && j[(m_last + k) % 4]) begin
                           found  = 1'b1;
                           m_road = (m_last + k) % 4;
                        end
                     end
                  end
                  if (found) begin
                     m_jam = 1; m_streak++; m_len = GJ;
                  end else begin
                     m_road = m_norm; m_norm = (m_norm + 1) % 4;
                     m_jam = 0; m_streak = 0; m_len = GN;
                  end
                  m_last = m_road; m_ph = 1; m_served = 0; m_ps = 1;
               end
            1: if (m_served == m_len ||
                   (m_jam == 0 && (j & ~(4'b0001 << m_road)) != 4'b0000 &&
                    m_streak < MJS && m_served >= MG)) begin
                  m_ph = 2; m_served = 0;
               end
            default: if (m_served == YC) begin
                  m_ph = 0; m_served = 0;
               end
         endcase
      end
      e.allow  = (m_ph == 1) ? 4'(1 << m_road) : 4'b0000;
      e.yellow = (m_ph == 2) ? 4'(1 << m_road) : 4'b0000;
      e.ph     = m_ph;
      e.road   = m_road;
      e.jam    = m_jam;
      e.ps     = m_ps;
      exp_q.push_back(e);
   endtask

   // Models the edge that consumes the current inputs, then drives the next inputs.
   task automatic step(input bit r, input bit t, input logic [3:0] j);
      @(posedge clk);
      model_step(rst, tick, jam);
      #1;
      rst  = r;
      tick = t;
      jam  = j;
   endtask

   bit   in_g = 1'b0;
   grn_t g_cur;

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("allow", int'(allow), int'(e.allow));
         check("yellow", int'(yellow), int'(e.yellow));
         check("phase", int'(phase), e.ph);
         check("current_road", int'(cur_road), e.road);
         check("jam_active", int'(jam_active), e.jam);
         check("phase_start", int'(phase_start), e.ps);
         check("lamp_onehot", int'($countones(allow | yellow) <= 1), 1);
         if (phase == 2'd1 && !in_g) begin
            in_g       = 1'b1;
            g_cur.road = int'(cur_road);
            g_cur.jam  = int'(jam_active);
            g_cur.len  = 0;
         end else if (phase != 2'd1 && in_g) begin
            in_g = 1'b0;
            green_log.push_back(g_cur);
         end
         if (rst) in_g = 1'b0;
         else if (in_g && tick) g_cur.len++;
      end
   end

   task automatic check_green(input int idx, input int road, input int jm, input int len);
      if (idx < green_log.size()) begin
         check($sformatf("green%0d_road", idx), green_log[idx].road, road);
         check($sformatf("green%0d_jam", idx), green_log[idx].jam, jm);
         check($sformatf("green%0d_len", idx), green_log[idx].len, len);
      end else begin
         n_vec++;
         n_err++;
         $display("FAIL green%0d_missing: got %0d greens, expected at least %0d",
                  idx, green_log.size(), idx + 1);
      end
   endtask

   int s3_road[7] = '{0, 2, 2, 1, 2, 2, 2};
   int s3_jam[7]  = '{0, 1, 1, 0, 1, 1, 0};
   int s3_len[7]  = '{4, 12, 12, 4, 12, 12, 8};
   int s4_road[4] = '{0, 1, 3, 1};
   int s4_jam[4]  = '{0, 1, 1, 0};
   int s4_len[4]  = '{8, 12, 12, 4};

   initial begin
      bit         r, t;
      logic [3:0] j;

      // Own-road jam held from the first green: preemption, streak cap, own jam ignored.
      step(1, 0, 4'b0000);
      step(1, 0, 4'b0000);
      step(0, 1, 4'b0000);
      green_log.delete();
      step(0, 1, 4'b0000);
      repeat (120) step(0, 1, 4'b0100);
      for (int i = 0; i < 7; i++) check_green(i, s3_road[i], s3_jam[i], s3_len[i]);

      // Jams on roads 1 and 3 appear after road 0 was served.
      step(1, 1, 4'b0000);
      step(0, 1, 4'b0000);
      green_log.delete();
      repeat (9) step(0, 1, 4'b0000);
      repeat (70) step(0, 1, 4'b1010);
      for (int i = 0; i < 4; i++) check_green(i, s4_road[i], s4_jam[i], s4_len[i]);

      // Tick freeze mid-green, then reset mid-yellow.
      step(1, 1, 4'b0000);
      repeat (5) step(0, 1, 4'b0000);
      repeat (5) step(0, 0, 4'b0000);
      repeat (6) step(0, 1, 4'b0000);
      step(1, 1, 4'b0000);
      repeat (20) step(0, 1, 4'b0000);

      // Randomised traffic.
      j = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
         r = ($urandom_range(0, 199) == 0);
         t = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0)
            j = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         step(r, t, j);
      end

      step(0, 0, 4'b0000);
      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
